// File: rtl/gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : gpio_debounce
// Purpose  : Per-pin input conditioning between the raw GPIO pads and the
//            GPIO controller input bus. Each pad goes through a 2-flop
//            synchroniser, then a glitch filter. The filter is a saturating
//            stable-sample counter. It accepts a level change only after
//            Teff = max(flt_thresh_i,1) consecutive differing samples.
//
// Ports    : hclk          clock
//            hreset        asynchronous reset, active-high
//            gpio_pad_i    raw asynchronous pad inputs        [GPIO_NUM]
//            flt_en_i      per-pin filter enable, 0 = bypass  [GPIO_NUM]
//            flt_thresh_i  samples required to accept change  [CNT_WIDTH]
//            presc_div_i   sample divider                     [PRESC_WIDTH]
//                          (only with GPIO_DEBOUNCE_PRESC_EN)
//            gpio_filt_o   filtered synchronous level         [GPIO_NUM]
//            gpio_chg_o    one-cycle pulse per filt change    [GPIO_NUM]
//
// Options  : define GPIO_DEBOUNCE_PRESC_EN to add the sample prescaler.
//            Enabled pins then sample only every presc_div_i+1 cycles.
//            Without it, every cycle is a sample tick.
//
// Revision : 1.0 - initial release
// ============================================================================
module gpio_debounce #(
    parameter int GPIO_NUM    = 32,
    parameter int CNT_WIDTH   = 8,
    parameter int PRESC_WIDTH = 16
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [GPIO_NUM-1:0]    gpio_pad_i,
    input  logic [GPIO_NUM-1:0]    flt_en_i,
    input  logic [CNT_WIDTH-1:0]   flt_thresh_i,
`ifdef GPIO_DEBOUNCE_PRESC_EN
    input  logic [PRESC_WIDTH-1:0] presc_div_i,
`endif
    output logic [GPIO_NUM-1:0]    gpio_filt_o,
    output logic [GPIO_NUM-1:0]    gpio_chg_o
);

    // Reject out-of-range configurations at elaboration time.
    if (GPIO_NUM < 1 || GPIO_NUM > 32 || CNT_WIDTH < 1 || PRESC_WIDTH < 1) begin : g_bad_params
        $error("gpio_debounce: parameter out of range");
    end

    localparam logic [CNT_WIDTH:0] c_one = (CNT_WIDTH+1)'(1);

    logic [GPIO_NUM-1:0]  r_sync0;
    logic [GPIO_NUM-1:0]  r_sync1;
    logic [GPIO_NUM-1:0]  r_filt;
    logic [GPIO_NUM-1:0]  r_chg;
    logic [GPIO_NUM-1:0]  w_filt_next;
    logic                 w_tick;
    logic [CNT_WIDTH:0]   w_teff;

    // Threshold of 0 behaves as 1. One extra bit lets cnt+1 be compared
    // without wrapping, so a counter at full scale always accepts.
    assign w_teff = (flt_thresh_i == '0) ? c_one : {1'b0, flt_thresh_i};

    // ------------------------------------------------------------------------
    // Sample tick
    // ------------------------------------------------------------------------
`ifdef GPIO_DEBOUNCE_PRESC_EN
    logic [PRESC_WIDTH-1:0] r_pc;

    // Use >= rather than ==. If the divider is lowered below the current
    // count, the next cycle ticks immediately instead of waiting for a wrap.
    assign w_tick = (r_pc >= presc_div_i);

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_pc <= '0;
        end else if (w_tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + PRESC_WIDTH'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    // ------------------------------------------------------------------------
    // Per-pin filter
    // ------------------------------------------------------------------------
    for (genvar i = 0; i < GPIO_NUM; i++) begin : g_pin
        logic [CNT_WIDTH-1:0] r_cnt;
        logic [CNT_WIDTH-1:0] w_cnt_next;
        logic [CNT_WIDTH:0]   w_cnt_inc;
        logic                 w_nf;

        assign w_cnt_inc = {1'b0, r_cnt} + c_one;

        always_comb begin
            w_nf       = r_filt[i];
            w_cnt_next = r_cnt;
            if (!flt_en_i[i]) begin
                // Bypass follows sync1 every cycle, regardless of the tick.
                w_nf       = r_sync1[i];
                w_cnt_next = '0;
            end else if (w_tick) begin
                if (r_sync1[i] == r_filt[i]) begin
                    w_cnt_next = '0;
                end else if (w_cnt_inc >= w_teff) begin
                    w_nf       = r_sync1[i];
                    w_cnt_next = '0;
                end else begin
                    w_cnt_next = w_cnt_inc[CNT_WIDTH-1:0];
                end
            end
        end

        assign w_filt_next[i] = w_nf;

        always_ff @(posedge hclk or posedge hreset) begin
            if (hreset) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= w_cnt_next;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Synchroniser, filtered level and change pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            r_sync0 <= '0;
            r_sync1 <= '0;
            r_filt  <= '0;
            r_chg   <= '0;
        end else begin
            r_sync0 <= gpio_pad_i;
            r_sync1 <= r_sync0;
            r_filt  <= w_filt_next;
            // Registered with filt, so the pulse coincides with the first
            // cycle in which the new level is visible.
            r_chg   <= w_filt_next ^ r_filt;
        end
    end

    assign gpio_filt_o = r_filt;
    assign gpio_chg_o  = r_chg;

endmodule
`default_nettype wire

// File: tb/tb_gpio_debounce.sv
`default_nettype none
// ============================================================================
// Module   : tb_gpio_debounce
// Purpose  : Self-checking bench for gpio_debounce. It uses a vector table
//            for bypass/T=0 timing, plus directed sequences for reset,
//            glitch rejection, threshold change, asynchronous reset
//            mid-count and, when GPIO_DEBOUNCE_PRESC_EN is defined, the
//            prescaler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gpio_debounce;

    localparam int N  = 32;
    localparam int CW = 8;
    localparam int PW = 16;

    logic          hclk = 1'b0;
    logic          hreset;
    logic [N-1:0]  gpio_pad_i;
    logic [N-1:0]  flt_en_i;
    logic [CW-1:0] flt_thresh_i;
    logic [N-1:0]  gpio_filt_o;
    logic [N-1:0]  gpio_chg_o;
`ifdef GPIO_DEBOUNCE_PRESC_EN
    logic [PW-1:0] presc_div_i;
`endif

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [N-1:0]  pad;
        logic [N-1:0]  en;
        logic [CW-1:0] thresh;
        logic [N-1:0]  filt;
        logic [N-1:0]  chg;
    } vec_t;

    vec_t vecs [18];

    always #5 hclk = ~hclk;

    gpio_debounce #(
        .GPIO_NUM   (N),
        .CNT_WIDTH  (CW),
        .PRESC_WIDTH(PW)
    ) dut (
        .hclk        (hclk),
        .hreset      (hreset),
        .gpio_pad_i  (gpio_pad_i),
        .flt_en_i    (flt_en_i),
        .flt_thresh_i(flt_thresh_i),
`ifdef GPIO_DEBOUNCE_PRESC_EN
        .presc_div_i (presc_div_i),
`endif
        .gpio_filt_o (gpio_filt_o),
        .gpio_chg_o  (gpio_chg_o)
    );

    // Advance one rising edge. Drive and sample 1 time unit after it.
    task automatic step();
        @(posedge hclk);
        #1;
    endtask

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reset with pads low. Release occurs 1 unit after an edge.
    task automatic do_reset();
        hreset     = 1'b1;
        gpio_pad_i = '0;
        step();
        step();
        hreset = 1'b0;
    endtask

    initial begin
        // Pad pattern for pin 0 and hand-derived filt/chg when Teff=1:
        // filt(k) = p(k-2), chg(k) = p(k-2) ^ p(k-3).
        int p  [9] = '{0, 1, 0, 0, 1, 0, 0, 0, 0};
        int ef [9] = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
        int ec [9] = '{0, 0, 0, 1, 1, 0, 1, 1, 0};
        logic [N-1:0] ef_v;
        logic [N-1:0] ec_v;

        for (int b = 0; b < 2; b++) begin
            for (int k = 0; k < 9; k++) begin
                vecs[b*9+k].pad    = (p[k]  != 0) ? 32'h1 : 32'h0;
                vecs[b*9+k].en     = (b == 0) ? 32'hFFFF_FFFE : 32'hFFFF_FFFF;
                vecs[b*9+k].thresh = (b == 0) ? 8'd4 : 8'd0;
                vecs[b*9+k].filt   = (ef[k] != 0) ? 32'h1 : 32'h0;
                vecs[b*9+k].chg    = (ec[k] != 0) ? 32'h1 : 32'h0;
            end
        end

        hreset       = 1'b0;
        gpio_pad_i   = '1;
        flt_en_i     = '1;
        flt_thresh_i = 8'd4;
`ifdef GPIO_DEBOUNCE_PRESC_EN
        presc_div_i  = '0;
`endif

        // ---- 1: reset clears without a clock, release latency Teff+2 ----
        #2 hreset = 1'b1;
        #1;
        check("rst_async_filt", gpio_filt_o, '0);
        check("rst_async_chg",  gpio_chg_o,  '0);
        step();
        check("rst_hold_filt", gpio_filt_o, '0);
        step();
        hreset = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            step();
            check("rst_rel_filt", gpio_filt_o, (k >= 6) ? 32'hFFFF_FFFF : 32'h0);
            check("rst_rel_chg",  gpio_chg_o,  (k == 6) ? 32'hFFFF_FFFF : 32'h0);
        end

        // ---- 2: glitch rejection on pin 3, T=4 ----
        do_reset();
        flt_en_i      = '1;
        flt_thresh_i  = 8'd4;
        gpio_pad_i[3] = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            if (k == 2) gpio_pad_i[3] = 1'b0;
            check("glitch3_filt", gpio_filt_o, '0);
            check("glitch3_chg",  gpio_chg_o,  '0);
        end
        gpio_pad_i[3] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("held4_filt", gpio_filt_o, (k >= 5) ? 32'h8 : 32'h0);
            check("held4_chg",  gpio_chg_o,  (k == 5) ? 32'h8 : 32'h0);
        end

        // ---- 3: bypass vs enabled T=0 give identical waveforms ----
        do_reset();
        for (int i = 0; i < 18; i++) begin
            gpio_pad_i   = vecs[i].pad;
            flt_en_i     = vecs[i].en;
            flt_thresh_i = vecs[i].thresh;
            step();
            ef_v = vecs[i].filt;
            ec_v = vecs[i].chg;
            check((i < 9) ? "byp_filt" : "t0_filt", gpio_filt_o, ef_v);
            check((i < 9) ? "byp_chg"  : "t0_chg",  gpio_chg_o,  ec_v);
        end

        // ---- 4: threshold lowered mid-count on pin 5 ----
        do_reset();
        flt_en_i      = '1;
        flt_thresh_i  = 8'd8;
        gpio_pad_i[5] = 1'b1;
        for (int k = 0; k <= 6; k++) begin
            step();
            check("thr_pre_filt", gpio_filt_o, '0);
        end
        flt_thresh_i = 8'd3;
        step();
        check("thr_new_filt", gpio_filt_o, 32'h20);
        check("thr_new_chg",  gpio_chg_o,  32'h20);
        gpio_pad_i[5] = 1'b0;
        for (int k = 8; k <= 12; k++) begin
            step();
            check("thr_fall_filt", gpio_filt_o, (k < 12) ? 32'h20 : 32'h0);
            check("thr_fall_chg",  gpio_chg_o,  (k == 12) ? 32'h20 : 32'h0);
        end

        // ---- 5: async reset mid-count, pin 7 filtered T=200, pin 8 bypassed ----
        do_reset();
        flt_en_i      = ~(32'h1 << 8);
        flt_thresh_i  = 8'd200;
        gpio_pad_i[7] = 1'b1;
        gpio_pad_i[8] = 1'b1;
        for (int k = 0; k < 100; k++) step();
        check("mid_pre_filt", gpio_filt_o, 32'h100);
        #2 hreset = 1'b1;
        #1;
        check("mid_async_filt", gpio_filt_o, '0);
        check("mid_async_chg",  gpio_chg_o,  '0);
        step();
        hreset = 1'b0;
        for (int k = 1; k <= 203; k++) begin
            step();
            check("mid_rel_filt", gpio_filt_o,
                  ((k >= 3) ? 32'h100 : 32'h0) | ((k >= 202) ? 32'h80 : 32'h0));
            check("mid_rel_chg", gpio_chg_o,
                  ((k == 3) ? 32'h100 : 32'h0) | ((k == 202) ? 32'h80 : 32'h0));
        end

`ifdef GPIO_DEBOUNCE_PRESC_EN
        // ---- 6: prescaler div=3 (tick on edges 4,8,12,...), T=2, pin 1 ----
        flt_en_i     = '1;
        flt_thresh_i = 8'd2;
        presc_div_i  = 16'd3;
        do_reset();
        for (int k = 1; k <= 30; k++) begin
            step();
            check("presc_filt", gpio_filt_o, (k >= 12) ? 32'h2 : 32'h0);
            check("presc_chg",  gpio_chg_o,  (k == 12) ? 32'h2 : 32'h0);
            if (k == 2)  gpio_pad_i[1] = 1'b1;
            if (k == 14) gpio_pad_i[1] = 1'b0;
            if (k == 17) gpio_pad_i[1] = 1'b1;
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
